// File: rtl/servo_pwm_dual.sv
// Two-axis frame-synchronous servo PWM generator with per-axis clamp and optional slew limiting.
// Optional feature: define SERVO_SLEW_EN to enable rv2/rh2 per-frame step limiting.
module servo_pwm_dual #(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned PW_MIN   = 500,
  parameter int unsigned PW_MAX   = 2500,
  parameter int unsigned PARK     = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ss,
  input  logic [15:0] rv1,
  input  logic [15:0] rv2,
  input  logic [15:0] rh1,
  input  logic [15:0] rh2,
  output logic        pwm_theta,
  output logic        pwm_phi,
  output logic [1:0]  busy,
  output logic        frame_tick
);

  localparam int unsigned PscW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FrmW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(TICK_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(FRAME_US - 1);
  localparam logic [15:0] PwMin = 16'(PW_MIN);
  localparam logic [15:0] PwMax = 16'(PW_MAX);
  localparam logic [15:0] Park  = 16'(PARK);

`ifdef SERVO_SLEW_EN
  typedef enum logic [1:0] {StIdle, StMove, StHold} axis_state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold} axis_state_e;
`endif

  logic [PscW-1:0] psc_q, psc_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            tick, boundary;
  logic [15:0]     frm_ext;

  logic [15:0]     tgt_raw [2];
  logic [15:0]     tgt     [2];
  logic [15:0]     cur_q   [2];
  logic [15:0]     cur_d   [2];
  logic [1:0]      en_q, en_d;
  logic [1:0]      pwm_q, pwm_d;
  logic            frame_tick_q;
  axis_state_e     state_q [2];
  axis_state_e     state_d [2];

`ifdef SERVO_SLEW_EN
  logic [15:0]     step    [2];
  logic [16:0]     diff    [2];
`endif

  always_comb begin
    tick     = (psc_q == PscLast);
    psc_d    = tick ? '0 : psc_q + PscW'(1);
    boundary = tick && (frm_q == FrmLast);
    frm_d    = frm_q;
    if (tick) begin
      frm_d = (frm_q == FrmLast) ? '0 : frm_q + FrmW'(1);
    end
    frm_ext  = 16'(frm_q);
  end

  // Register inputs are only consumed at the frame boundary, so mid-frame writes never glitch.
  always_comb begin
    tgt_raw[0] = rv1;
    tgt_raw[1] = rh1;
`ifdef SERVO_SLEW_EN
    step[0]    = rv2;
    step[1]    = rh2;
`endif
    for (int a = 0; a < 2; a++) begin
      tgt[a]     = (tgt_raw[a] < PwMin) ? PwMin :
                   (tgt_raw[a] > PwMax) ? PwMax : tgt_raw[a];
      en_d[a]    = en_q[a];
      cur_d[a]   = cur_q[a];
      state_d[a] = state_q[a];
`ifdef SERVO_SLEW_EN
      diff[a]    = (tgt[a] >= cur_q[a]) ? {1'b0, tgt[a]} - {1'b0, cur_q[a]}
                                        : {1'b0, cur_q[a]} - {1'b0, tgt[a]};
`endif
      if (boundary) begin
        en_d[a] = ss[a];
        if (ss[a]) begin
`ifdef SERVO_SLEW_EN
          if ((step[a] == 16'd0) || (diff[a] <= {1'b0, step[a]})) begin
            cur_d[a] = tgt[a];
          end else if (tgt[a] > cur_q[a]) begin
            cur_d[a] = cur_q[a] + step[a];
          end else begin
            cur_d[a] = cur_q[a] - step[a];
          end
`else
          cur_d[a] = tgt[a];
`endif
        end
`ifdef SERVO_SLEW_EN
        state_d[a] = !ss[a] ? StIdle : ((cur_d[a] == tgt[a]) ? StHold : StMove);
`else
        state_d[a] = ss[a] ? StHold : StIdle;
`endif
      end
      pwm_d[a] = en_q[a] && (frm_ext < cur_q[a]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q        <= '0;
      frm_q        <= '0;
      en_q         <= '0;
      pwm_q        <= '0;
      frame_tick_q <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        cur_q[a]   <= Park;
        state_q[a] <= StIdle;
      end
    end else begin
      psc_q        <= psc_d;
      frm_q        <= frm_d;
      en_q         <= en_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= boundary;
      for (int a = 0; a < 2; a++) begin
        cur_q[a]   <= cur_d[a];
        state_q[a] <= state_d[a];
      end
    end
  end

`ifdef SERVO_SLEW_EN
  always_comb begin
    busy = 2'b00;
    for (int a = 0; a < 2; a++) begin
      busy[a] = (state_q[a] == StMove);
    end
  end
`else
  // Step inputs have no function without slew limiting.
  logic unused_step;
  assign unused_step = ^{rv2, rh2};
  assign busy        = 2'b00;
`endif

  assign pwm_theta  = pwm_q[0];
  assign pwm_phi    = pwm_q[1];
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_pwm_dual.sv
// Self-checking bench for servo_pwm_dual: directed vector table, corner sequences and
// randomized frames checked against a per-frame arithmetic model.
`timescale 1ns/1ps
module tb_servo_pwm_dual;

  localparam int TD       = 2;
  localparam int FU       = 100;
  localparam int PMIN     = 10;
  localparam int PMAX     = 50;
  localparam int PRK      = 30;
  localparam int FrameClk = TD * FU;
`ifdef SERVO_SLEW_EN
  localparam bit Slew = 1'b1;
`else
  localparam bit Slew = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ss  = 2'b00;
  logic [15:0] rv1 = '0, rv2 = '0, rh1 = '0, rh2 = '0;
  logic        pwm_theta, pwm_phi, frame_tick;
  logic [1:0]  busy;

  servo_pwm_dual #(
    .TICK_DIV(TD), .FRAME_US(FU), .PW_MIN(PMIN), .PW_MAX(PMAX), .PARK(PRK)
  ) dut (
    .clk(clk), .rst(rst), .ss(ss), .rv1(rv1), .rv2(rv2), .rh1(rh1), .rh2(rh2),
    .pwm_theta(pwm_theta), .pwm_phi(pwm_phi), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one update per frame boundary, plain integer arithmetic.
  int m_cur [2];
  int m_en  [2];
  int m_bsy [2];

  function automatic int clampv(input int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_cur[a] = PRK;
      m_en[a]  = 0;
      m_bsy[a] = 0;
    end
  endtask

  task automatic model_boundary(input logic [1:0] s, input logic [15:0] t0, input logic [15:0] s0,
                                input logic [15:0] t1, input logic [15:0] s1);
    int tg [2];
    int st [2];
    int d;
    tg[0] = clampv(int'(t0)); st[0] = int'(s0);
    tg[1] = clampv(int'(t1)); st[1] = int'(s1);
    for (int a = 0; a < 2; a++) begin
      m_en[a] = int'(s[a]);
      if (m_en[a] != 0) begin
        d = tg[a] - m_cur[a];
        if (!Slew || st[a] == 0 || (d < 0 ? -d : d) <= st[a]) m_cur[a] = tg[a];
        else m_cur[a] = m_cur[a] + (d > 0 ? st[a] : -st[a]);
      end
      m_bsy[a] = (Slew && m_en[a] != 0 && m_cur[a] != tg[a]) ? 1 : 0;
    end
  endtask

  function automatic int exp_w(input int a);
    return (m_en[a] != 0) ? m_cur[a] * TD : 0;
  endfunction

  function automatic int exp_busy();
    return m_bsy[1] * 2 + m_bsy[0];
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n <= 2 * FrameClk);
  endtask

  // Samples one frame starting at the current (frame_tick) negedge; mode 1 scrambles the
  // register inputs mid-frame, mode 2 drops both enables mid-pulse.
  task automatic measure(input int mode, output int wt, output int wp, output int nft,
                         output int bz);
    wt = 0; wp = 0; nft = 0; bz = int'(busy);
    for (int i = 0; i < FrameClk; i++) begin
      if (i > 0) @(negedge clk);
      wt  += int'(pwm_theta);
      wp  += int'(pwm_phi);
      nft += int'(frame_tick);
      if (i == 20 && mode == 1) begin
        ss  = 2'($urandom);
        rv1 = 16'($urandom);
        rv2 = 16'($urandom);
        rh1 = 16'($urandom);
        rh2 = 16'($urandom);
      end
      if (i == 20 && mode == 2) ss = 2'b00;
    end
  endtask

  task automatic do_frame(input string name, input logic [1:0] s, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                          input int mode, output int wt, output int wp, output int bz);
    int n, nft;
    ss = s; rv1 = a; rv2 = b; rh1 = c; rh2 = d;
    model_boundary(s, a, b, c, d);
    wait_tick(n);
    check({name, "_period"}, n, 1);
    measure(mode, wt, wp, nft, bz);
    check({name, "_ticks"}, nft, 1);
  endtask

  typedef struct {
    logic [1:0]  ss;
    logic [15:0] rv1, rv2, rh1, rh2;
    int          wt, wp, bz;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int n, wt, wp, bz, nft;
    logic [1:0]  rs;
    logic [15:0] r0, r1, r2, r3;

    vecs[0]  = '{2'b00, 16'd0,   16'd0,  16'd0,   16'd0,  0,               0,               0};
    vecs[1]  = '{2'b01, 16'd30,  16'd0,  16'd0,   16'd0,  60,              0,               0};
    vecs[2]  = '{2'b11, 16'd30,  16'd0,  16'd50,  16'd8,  60,  Slew ? 76 : 100, Slew ? 2 : 0};
    vecs[3]  = '{2'b11, 16'd30,  16'd0,  16'd50,  16'd8,  60,  Slew ? 92 : 100, Slew ? 2 : 0};
    vecs[4]  = '{2'b11, 16'd30,  16'd0,  16'd50,  16'd8,  60,              100,             0};
    vecs[5]  = '{2'b11, 16'd5,   16'd0,  16'd50,  16'd8,  20,              100,             0};
    vecs[6]  = '{2'b11, 16'd900, 16'd0,  16'd50,  16'd8,  100,             100,             0};
    vecs[7]  = '{2'b11, 16'd900, 16'd0,  16'd900, 16'd8,  100,             100,             0};
    vecs[8]  = '{2'b11, 16'd900, 16'd0,  16'd0,   16'd15, 100, Slew ? 70 : 20,  Slew ? 2 : 0};
    vecs[9]  = '{2'b11, 16'd900, 16'd0,  16'd0,   16'd15, 100, Slew ? 40 : 20,  Slew ? 2 : 0};
    vecs[10] = '{2'b11, 16'd900, 16'd0,  16'd0,   16'd15, 100,             20,              0};
    vecs[11] = '{2'b10, 16'd900, 16'd0,  16'd0,   16'd15, 0,               20,              0};
    vecs[12] = '{2'b11, 16'd0,   16'd20, 16'd0,   16'd15, Slew ? 60 : 20,  20,  Slew ? 1 : 0};

    // Reset state and first-frame timing.
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pwm_theta", int'(pwm_theta), 0);
    check("rst_pwm_phi", int'(pwm_phi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    rst = 1'b1;
    model_boundary(2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    wait_tick(n);
    check("first_tick_delay", n, FrameClk);
    measure(0, wt, wp, nft, bz);
    check("idle_theta", wt, 0);
    check("idle_phi", wp, 0);
    check("idle_busy", bz, 0);
    check("idle_ticks", nft, 1);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].ss, vecs[i].rv1, vecs[i].rv2, vecs[i].rh1,
               vecs[i].rh2, 1, wt, wp, bz);
      check($sformatf("vec%0d_theta", i), wt, vecs[i].wt);
      check($sformatf("vec%0d_phi", i), wp, vecs[i].wp);
      check($sformatf("vec%0d_busy", i), bz, vecs[i].bz);
    end

    // Enable dropped mid-pulse: pulse completes, next frame is low.
    do_frame("midoff", 2'b01, 16'd30, 16'd0, 16'd0, 16'd0, 2, wt, wp, bz);
    check("midoff_theta", wt, 60);
    check("midoff_phi", wp, 0);
    do_frame("afteroff", 2'b00, 16'd30, 16'd0, 16'd0, 16'd0, 0, wt, wp, bz);
    check("afteroff_theta", wt, 0);

    // Reset asserted mid-pulse.
    ss = 2'b11; rv1 = 16'd50; rv2 = 16'd0; rh1 = 16'd50; rh2 = 16'd0;
    wait_tick(n);
    check("prerst_period", n, 1);
    repeat (10) @(negedge clk);
    check("prerst_pwm_theta", int'(pwm_theta), 1);
    rst = 1'b0;
    #1;
    check("midrst_pwm_theta", int'(pwm_theta), 0);
    check("midrst_pwm_phi", int'(pwm_phi), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_tick", int'(frame_tick), 0);
    repeat (3) @(negedge clk);
    model_reset();
    ss = 2'b11; rv1 = 16'd40; rv2 = 16'd4; rh1 = 16'd20; rh2 = 16'd0;
    rst = 1'b1;
    model_boundary(ss, rv1, rv2, rh1, rh2);
    wait_tick(n);
    check("rerst_tick_delay", n, FrameClk);
    measure(0, wt, wp, nft, bz);
    check("rerst_theta", wt, exp_w(0));
    check("rerst_phi", wp, exp_w(1));
    check("rerst_busy", bz, exp_busy());

    // Randomized frames against the model.
    for (int k = 0; k < 30; k++) begin
      rs = 2'($urandom_range(0, 3));
      r0 = 16'($urandom_range(0, 70));
      r2 = 16'($urandom_range(0, 70));
      if ($urandom_range(0, 7) == 0) r0 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r2 = 16'($urandom);
      r1 = 16'($urandom_range(0, 12));
      r3 = 16'($urandom_range(0, 12));
      do_frame($sformatf("rnd%0d", k), rs, r0, r1, r2, r3, 1, wt, wp, bz);
      check($sformatf("rnd%0d_theta", k), wt, exp_w(0));
      check($sformatf("rnd%0d_phi", k), wp, exp_w(1));
      check($sformatf("rnd%0d_busy", k), bz, exp_busy());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
